// File: rtl/if_id_buffer.sv
// if_id_buffer: show-ahead {pc, instr} FIFO decoupling fetch from decode, with flush.
// Optional stall/flush statistics outputs are built when IF_ID_BUFFER_STATS_EN is defined.
module if_id_buffer #(
    parameter int                XLEN  = 32,
    parameter int                DEPTH = 2,
    parameter logic [XLEN-1:0]   NOP   = 32'h00000013
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         if_valid,
    output logic                         if_ready,
    input  logic [XLEN-1:0]              if_pc,
    input  logic [XLEN-1:0]              if_instr,
    output logic                         id_valid,
    input  logic                         id_ready,
    output logic [XLEN-1:0]              id_pc,
    output logic [XLEN-1:0]              id_instr,
`ifdef IF_ID_BUFFER_STATS_EN
    output logic [31:0]                  stall_cycles,
    output logic [31:0]                  flush_drops,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int            PW       = $clog2(DEPTH);
    localparam int            CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [XLEN-1:0] instr_mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   rd_ptr_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            empty_s;
    logic            full_s;
    logic            push_s;
    logic            pop_s;
    logic            wr_en_s;

    // Handshake decode from registered occupancy only, so if_ready never sees id_ready.
    always_comb begin
        empty_s = (count_q == {CW{1'b0}});
        full_s  = (count_q == FULL_CNT);
        push_s  = if_valid & ~full_s;
        pop_s   = id_ready & ~empty_s;
        wr_en_s = push_s & ~flush & ~reset;
    end

    // Pointer and occupancy next state; flush drops everything including this cycle's push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is deliberately never cleared; the empty masking hides stale words.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            pc_mem_q[wr_ptr_q]    <= if_pc;
            instr_mem_q[wr_ptr_q] <= if_instr;
        end
    end

    // Show-ahead head with empty masking.
    always_comb begin
        if_ready = ~full_s;
        id_valid = ~empty_s;
        count    = count_q;
        if (empty_s) begin
            id_pc    = {XLEN{1'b0}};
            id_instr = NOP;
        end else begin
            id_pc    = pc_mem_q[rd_ptr_q];
            id_instr = instr_mem_q[rd_ptr_q];
        end
    end

`ifdef IF_ID_BUFFER_STATS_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] stall_cycles_d;
    logic [31:0] flush_drops_q;
    logic [31:0] flush_drops_d;

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[32]) begin
            sat_add32 = 32'hFFFF_FFFF;
        end else begin
            sat_add32 = sum[31:0];
        end
    endfunction

    // Counter next state; drops count what was held, never the discarded push.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_drops_d  = flush_drops_q;
        if (~empty_s & ~id_ready) begin
            stall_cycles_d = sat_add32(stall_cycles_q, 32'd1);
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
        if (flush) begin
            flush_drops_d = sat_add32(flush_drops_q, 32'(count_q));
        end else begin
            flush_drops_d = flush_drops_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_q <= 32'd0;
            flush_drops_q  <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_drops_q  <= flush_drops_d;
        end
    end

    // Registered statistics outputs.
    always_comb begin
        stall_cycles = stall_cycles_q;
        flush_drops  = flush_drops_q;
    end
`endif

    if_id_buffer_checker #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_checker (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .if_valid (if_valid),
        .if_ready (if_ready),
        .if_pc    (if_pc),
        .if_instr (if_instr),
        .push     (push_s),
        .count    (count_q)
    );

endmodule

// Simulation-only protocol and occupancy checks for if_id_buffer.
module if_id_buffer_checker #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input logic            clk,
    input logic            reset,
    input logic            flush,
    input logic            if_valid,
    input logic            if_ready,
    input logic [XLEN-1:0] if_pc,
    input logic [XLEN-1:0] if_instr,
    input logic            push,
    input logic [CW-1:0]   count
);

    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count <= CW'(DEPTH));

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        push |-> if_ready);

    // A refused offer must be repeated unchanged unless a flush redirects fetch.
    a_offer_stable: assert property (@(posedge clk) disable iff (reset)
        (if_valid && !if_ready && !flush) |=>
            (if_valid && $stable(if_pc) && $stable(if_instr)));

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_if_id_buffer;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        flush    = 1'b0;
    logic        if_valid = 1'b0;
    logic        id_ready = 1'b0;
    logic [31:0] if_pc    = 32'd0;
    logic [31:0] if_instr = 32'd0;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [1:0]  count;
`ifdef IF_ID_BUFFER_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_drops;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of {pc, instr}, oldest at index 0.
    logic [63:0] mq[$];
    longint      m_stall = 0;
    longint      m_drops = 0;
    int          exp_count;
    logic        exp_valid;
    logic        exp_ready;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;

    if_id_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .NOP(NOP)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_pc        (if_pc),
        .if_instr     (if_instr),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_pc        (id_pc),
        .id_instr     (id_instr),
`ifdef IF_ID_BUFFER_STATS_EN
        .stall_cycles (stall_cycles),
        .flush_drops  (flush_drops),
`endif
        .count        (count)
    );

    always #5 clk = ~clk;

    // Advance one clock, updating the model from the inputs presented this cycle.
    task automatic tick();
        int sz;
        bit push;
        bit pop;
        sz   = mq.size();
        push = if_valid && (sz < DEPTH);
        pop  = (sz > 0) && id_ready;
        if (reset) begin
            mq.delete();
            m_stall = 0;
            m_drops = 0;
        end else begin
            if (sz > 0 && !id_ready && m_stall < 64'hFFFF_FFFF) m_stall = m_stall + 1;
            if (flush) begin
                m_drops = (m_drops + sz > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_drops + sz;
                mq.delete();
            end else begin
                if (pop) void'(mq.pop_front());
                if (push) mq.push_back({if_pc, if_instr});
            end
        end
        @(posedge clk);
        #1;
        exp_count = mq.size();
        exp_valid = (mq.size() > 0);
        exp_ready = (mq.size() < DEPTH);
        exp_pc    = (mq.size() > 0) ? mq[0][63:32] : 32'd0;
        exp_instr = (mq.size() > 0) ? mq[0][31:0]  : NOP;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_id_valid got=%0b want=0", id_valid); end
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL reset_if_ready got=%0b want=1", if_ready); end
        checks++; if (count !== 2'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", count); end
        checks++; if (id_instr !== 32'h00000013) begin failures++; $display("FAIL reset_id_instr got=%h want=00000013", id_instr); end
        checks++; if (id_pc !== 32'd0) begin failures++; $display("FAIL reset_id_pc got=%h want=0", id_pc); end
    endtask

    task automatic test_single_push();
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h0; if_instr = 32'hAAAA0001;
        tick();
        if_valid = 1'b0;
        checks++; if (id_valid !== 1'b1) begin failures++; $display("FAIL push1_id_valid got=%0b want=1", id_valid); end
        checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL push1_id_pc got=%h want=0", id_pc); end
        checks++; if (id_instr !== 32'hAAAA0001) begin failures++; $display("FAIL push1_id_instr got=%h want=aaaa0001", id_instr); end
        checks++; if (count !== 2'd1) begin failures++; $display("FAIL push1_count got=%0d want=1", count); end
    endtask

    task automatic test_fill_stall();
        if_valid = 1'b1; if_pc = 32'h4; if_instr = 32'hAAAA0002;
        tick();
        checks++; if (count !== 2'd2) begin failures++; $display("FAIL full_count got=%0d want=2", count); end
        checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL full_if_ready got=%0b want=0", if_ready); end
        if_pc = 32'h8; if_instr = 32'hAAAA0003;
        tick();
        checks++; if (count !== 2'd2) begin failures++; $display("FAIL held_count got=%0d want=2", count); end
        checks++; if (id_pc !== 32'h0) begin failures++; $display("FAIL held_head got=%h want=0", id_pc); end
        id_ready = 1'b1;
        tick();
        checks++; if (id_pc !== 32'h4) begin failures++; $display("FAIL drain1_head got=%h want=4", id_pc); end
        checks++; if (count !== 2'd1) begin failures++; $display("FAIL drain1_count got=%0d want=1", count); end
        checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL drain1_if_ready got=%0b want=1", if_ready); end
        tick();
        if_valid = 1'b0;
        checks++; if (id_pc !== 32'h8 || id_instr !== 32'hAAAA0003) begin failures++; $display("FAIL accept8_head got=%h/%h want=8/aaaa0003", id_pc, id_instr); end
        tick();
        checks++; if (id_valid !== 1'b0 || id_instr !== NOP || id_pc !== 32'd0) begin failures++; $display("FAIL drained_empty got=%0b/%h/%h want=0/00000013/0", id_valid, id_instr, id_pc); end
    endtask

    task automatic test_simul_push_pop();
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h8; if_instr = 32'hBBBB0008;
        tick();
        id_ready = 1'b1; if_pc = 32'hC; if_instr = 32'hBBBB000C;
        tick();
        checks++; if (count !== 2'd1) begin failures++; $display("FAIL pushpop_count got=%0d want=1", count); end
        checks++; if (id_pc !== 32'hC) begin failures++; $display("FAIL pushpop_head got=%h want=c", id_pc); end
        for (int i = 0; i < 20; i++) begin
            if_valid = (i < 16);
            if_pc    = 32'h10 + 32'(4 * i);
            if_instr = $urandom;
            tick();
            checks++;
            if (count !== exp_count[1:0] || id_valid !== exp_valid || id_pc !== exp_pc || id_instr !== exp_instr) begin
                failures++;
                $display("FAIL stream[%0d] got cnt=%0d v=%0b pc=%h in=%h want cnt=%0d v=%0b pc=%h in=%h",
                         i, count, id_valid, id_pc, id_instr, exp_count, exp_valid, exp_pc, exp_instr);
            end
        end
        if_valid = 1'b0;
    endtask

    task automatic test_flush();
        reset = 1'b1;
        tick();
        reset = 1'b0; id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h20; if_instr = 32'hCCCC0020;
        tick();
        if_pc = 32'h24; if_instr = 32'hCCCC0024;
        tick();
        flush = 1'b1; if_pc = 32'h40; if_instr = 32'hCCCC0040;
        tick();
        flush = 1'b0; if_valid = 1'b0;
        checks++; if (count !== 2'd0 || id_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got cnt=%0d v=%0b want 0/0", count, id_valid); end
`ifdef IF_ID_BUFFER_STATS_EN
        checks++; if (flush_drops !== 32'd2) begin failures++; $display("FAIL flush_drops got=%0d want=2", flush_drops); end
`endif
        tick();
        checks++; if (id_valid !== 1'b0 || id_instr !== NOP) begin failures++; $display("FAIL flush_not_stored got v=%0b in=%h want 0/00000013", id_valid, id_instr); end
        if_valid = 1'b1; if_pc = 32'h50; if_instr = 32'hCCCC0050;
        tick();
        flush = 1'b1; if_pc = 32'h54; if_instr = 32'hCCCC0054;
        tick();
        flush = 1'b0; if_valid = 1'b0;
        tick();
        checks++; if (count !== 2'd0 || id_valid !== 1'b0) begin failures++; $display("FAIL flush_push_dropped got cnt=%0d v=%0b want 0/0", count, id_valid); end
`ifdef IF_ID_BUFFER_STATS_EN
        checks++; if (flush_drops !== 32'd3) begin failures++; $display("FAIL flush_drops2 got=%0d want=3", flush_drops); end
        checks++; if (stall_cycles !== m_stall[31:0]) begin failures++; $display("FAIL flush_stalls got=%0d want=%0d", stall_cycles, m_stall); end
`endif
    endtask

    task automatic test_reset_midflight();
        id_ready = 1'b0;
        if_valid = 1'b1; if_pc = 32'h60; if_instr = 32'hDDDD0060;
        tick();
        if_pc = 32'h64; if_instr = 32'hDDDD0064;
        tick();
        if_valid = 1'b0; id_ready = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (count !== 2'd0 || id_valid !== 1'b0) begin failures++; $display("FAIL rst_mid got cnt=%0d v=%0b want 0/0", count, id_valid); end
        checks++; if (id_instr !== NOP || if_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_out got in=%h rdy=%0b want 00000013/1", id_instr, if_ready); end
`ifdef IF_ID_BUFFER_STATS_EN
        checks++; if (stall_cycles !== 32'd0) begin failures++; $display("FAIL rst_mid_stalls got=%0d want=0", stall_cycles); end
`endif
    endtask

    task automatic test_random();
        bit hold;
        for (int i = 0; i < 600; i++) begin
            hold = if_valid && (mq.size() >= DEPTH) && !flush && !reset;
            tick();
            checks++;
            if (count !== exp_count[1:0] || id_valid !== exp_valid || if_ready !== exp_ready ||
                id_pc !== exp_pc || id_instr !== exp_instr) begin
                failures++;
                $display("FAIL random[%0d] got cnt=%0d v=%0b r=%0b pc=%h in=%h want cnt=%0d v=%0b r=%0b pc=%h in=%h",
                         i, count, id_valid, if_ready, id_pc, id_instr,
                         exp_count, exp_valid, exp_ready, exp_pc, exp_instr);
            end
`ifdef IF_ID_BUFFER_STATS_EN
            checks++;
            if (stall_cycles !== m_stall[31:0] || flush_drops !== m_drops[31:0]) begin
                failures++;
                $display("FAIL random_stats[%0d] got st=%0d fd=%0d want st=%0d fd=%0d",
                         i, stall_cycles, flush_drops, m_stall, m_drops);
            end
`endif
            if (!hold) begin
                if_valid = ($urandom_range(0, 3) != 0);
                if_pc    = $urandom;
                if_instr = $urandom;
            end
            id_ready = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            reset    = ($urandom_range(0, 63) == 0);
        end
        if_valid = 1'b0; flush = 1'b0; reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_stall();
        test_simul_push_pop();
        test_flush();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
